// File: rtl/alu_operand_stage.sv
// ALU operand staging: two independent source selectors feed registered
// operands A/B, a TEMP feedback register, and a 4-state load/ack handshake.
module alu_operand_stage #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic              ld_a,
  input  logic              ld_b,
  input  logic [DATA_W-1:0] a_reg,
  input  logic [DATA_W-1:0] x_reg,
  input  logic [DATA_W-1:0] y_reg,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] sp,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              tmp_ld,
  input  logic              alu_ack,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] tmp,
  output logic              op_valid
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HAVE_A = 2'd1,
    ST_HAVE_B = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  localparam logic [DATA_W-1:0] CONST_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;
  logic [DATA_W-1:0] src_a_s, src_b_s;

  function automatic logic [DATA_W-1:0] src_sel(
    input logic [SEL_W-1:0]  sel,
    input logic [DATA_W-1:0] a_v,
    input logic [DATA_W-1:0] x_v,
    input logic [DATA_W-1:0] y_v,
    input logic [DATA_W-1:0] din_v,
    input logic [DATA_W-1:0] sp_v,
    input logic [DATA_W-1:0] tmp_v
  );
    logic [DATA_W-1:0] r;
    case (sel)
      3'd1:    r = a_v;
      3'd2:    r = x_v;
      3'd3:    r = y_v;
      3'd4:    r = din_v;
      3'd5:    r = sp_v;
      3'd6:    r = CONST_ONE;
      3'd7:    r = tmp_v;
      default: r = din_v;
    endcase
    return r;
  endfunction

  // Next state as seen from EMPTY; also reused for ack+load pipelining in READY.
  function automatic state_e from_empty(input logic la, input logic lb);
    state_e s;
    case ({la, lb})
      2'b11:   s = ST_READY;
      2'b10:   s = ST_HAVE_A;
      2'b01:   s = ST_HAVE_B;
      default: s = ST_EMPTY;
    endcase
    return s;
  endfunction

  // Independent source decode per channel; TEMP is read pre-update (no bypass).
  always_comb begin
    src_a_s = src_sel(sel_a, a_reg, x_reg, y_reg, data_in, sp, tmp_q);
    src_b_s = src_sel(sel_b, a_reg, x_reg, y_reg, data_in, sp, tmp_q);
  end

  // Next-value logic for operand and TEMP registers.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    tmp_d  = tmp_q;
    if (ld_a) op_a_d = src_a_s;
    else      op_a_d = op_a_q;
    if (ld_b) op_b_d = src_b_s;
    else      op_b_d = op_b_q;
    if (tmp_ld) tmp_d = alu_result;
    else        tmp_d = tmp_q;
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q <= {DATA_W{1'b0}};
      op_b_q <= {DATA_W{1'b0}};
      tmp_q  <= {DATA_W{1'b0}};
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      tmp_q  <= tmp_d;
    end
  end

  // Handshake FSM; alu_ack only matters in READY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:  state_q <= from_empty(ld_a, ld_b);
        ST_HAVE_A: state_q <= ld_b ? ST_READY : ST_HAVE_A;
        ST_HAVE_B: state_q <= ld_a ? ST_READY : ST_HAVE_B;
        ST_READY:  state_q <= alu_ack ? from_empty(ld_a, ld_b) : ST_READY;
        default:   state_q <= ST_EMPTY;
      endcase
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign tmp      = tmp_q;
  assign op_valid = (state_q == ST_READY);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: 8-bit instance plus a 16-bit instance.
module tb_alu_operand_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sel_a, sel_b;
  logic       ld_a, ld_b, tmp_ld, alu_ack;
  logic [7:0] a_reg, x_reg, y_reg, data_in, sp, alu_result;
  logic [7:0] op_a, op_b, tmp;
  logic       op_valid;
  logic [15:0] a16, x16, y16, din16, sp16, res16;
  logic [15:0] op_a16, op_b16, tmp16;
  logic        op_valid16;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_W(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sel_a(sel_a), .sel_b(sel_b),
    .ld_a(ld_a), .ld_b(ld_b), .a_reg(a_reg), .x_reg(x_reg), .y_reg(y_reg),
    .data_in(data_in), .sp(sp), .alu_result(alu_result), .tmp_ld(tmp_ld),
    .alu_ack(alu_ack), .op_a(op_a), .op_b(op_b), .tmp(tmp), .op_valid(op_valid)
  );

  alu_operand_stage #(.DATA_W(16), .SEL_W(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .sel_a(sel_a), .sel_b(sel_b),
    .ld_a(ld_a), .ld_b(ld_b), .a_reg(a16), .x_reg(x16), .y_reg(y16),
    .data_in(din16), .sp(sp16), .alu_result(res16), .tmp_ld(tmp_ld),
    .alu_ack(alu_ack), .op_a(op_a16), .op_b(op_b16), .tmp(tmp16), .op_valid(op_valid16)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes;
    ld_a = 1'b0; ld_b = 1'b0; tmp_ld = 1'b0; alu_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ld_a = 1'b1; ld_b = 1'b1; tmp_ld = 1'b1; alu_ack = 1'b1;
    sel_a = 3'd1; sel_b = 3'd2; a_reg = 8'hAA; x_reg = 8'h55; alu_result = 8'h99;
    tick();
    tick();
    n_cmp++; if (op_a !== 8'h00) begin n_mis++; $display("FAIL reset_op_a: got %h want 00", op_a); end
    n_cmp++; if (op_b !== 8'h00) begin n_mis++; $display("FAIL reset_op_b: got %h want 00", op_b); end
    n_cmp++; if (tmp !== 8'h00) begin n_mis++; $display("FAIL reset_tmp: got %h want 00", tmp); end
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", op_valid); end
    n_cmp++; if (op_a16 !== 16'h0000) begin n_mis++; $display("FAIL reset_op_a16: got %h want 0000", op_a16); end
    rst_n = 1'b1; idle_strobes();
    tick();
  endtask

  task automatic test_both_load;
    a_reg = 8'h3C; sel_a = 3'd1; sel_b = 3'd6; ld_a = 1'b1; ld_b = 1'b1;
    tick();
    idle_strobes();
    n_cmp++; if (op_a !== 8'h3C) begin n_mis++; $display("FAIL both_op_a: got %h want 3c", op_a); end
    n_cmp++; if (op_b !== 8'h01) begin n_mis++; $display("FAIL both_op_b: got %h want 01", op_b); end
    n_cmp++; if (op_valid !== 1'b1) begin n_mis++; $display("FAIL both_valid: got %b want 1", op_valid); end
    tick();
    n_cmp++; if (op_valid !== 1'b1) begin n_mis++; $display("FAIL ready_hold: got %b want 1", op_valid); end
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL ack_empty: got %b want 0", op_valid); end
    n_cmp++; if (op_a !== 8'h3C) begin n_mis++; $display("FAIL op_a_hold: got %h want 3c", op_a); end
  endtask

  task automatic test_staggered;
    sel_a = 3'd2; x_reg = 8'h10; ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL stag_valid0: got %b want 0", op_valid); end
    tick();
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL stag_valid1: got %b want 0", op_valid); end
    sel_b = 3'd4; data_in = 8'hF0; ld_b = 1'b1;
    tick();
    ld_b = 1'b0;
    n_cmp++; if (op_valid !== 1'b1) begin n_mis++; $display("FAIL stag_valid2: got %b want 1", op_valid); end
    n_cmp++; if (op_a !== 8'h10) begin n_mis++; $display("FAIL stag_op_a: got %h want 10", op_a); end
    n_cmp++; if (op_b !== 8'hF0) begin n_mis++; $display("FAIL stag_op_b: got %h want f0", op_b); end
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
  endtask

  task automatic test_tmp_no_bypass;
    tmp_ld = 1'b1; alu_result = 8'h7F;
    tick();
    n_cmp++; if (tmp !== 8'h7F) begin n_mis++; $display("FAIL tmp_load: got %h want 7f", tmp); end
    alu_result = 8'h80; ld_a = 1'b1; sel_a = 3'd7;
    tick();
    idle_strobes();
    n_cmp++; if (op_a !== 8'h7F) begin n_mis++; $display("FAIL tmp_nobypass: got %h want 7f", op_a); end
    n_cmp++; if (tmp !== 8'h80) begin n_mis++; $display("FAIL tmp_new: got %h want 80", tmp); end
    alu_result = 8'h11;
    tick();
    n_cmp++; if (tmp !== 8'h80) begin n_mis++; $display("FAIL tmp_hold: got %h want 80", tmp); end
    ld_b = 1'b1; sel_b = 3'd7;
    tick();
    ld_b = 1'b0;
    n_cmp++; if (op_b !== 8'h80) begin n_mis++; $display("FAIL tmp_to_b: got %h want 80", op_b); end
    n_cmp++; if (op_valid !== 1'b1) begin n_mis++; $display("FAIL havea_to_ready: got %b want 1", op_valid); end
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
  endtask

  task automatic test_decode;
    logic [7:0] exp_tbl [8];
    exp_tbl[0] = 8'h44; exp_tbl[1] = 8'h11; exp_tbl[2] = 8'h22; exp_tbl[3] = 8'h33;
    exp_tbl[4] = 8'h44; exp_tbl[5] = 8'h55; exp_tbl[6] = 8'h01; exp_tbl[7] = 8'h80;
    a_reg = 8'h11; x_reg = 8'h22; y_reg = 8'h33; data_in = 8'h44; sp = 8'h55;
    for (int i = 0; i < 8; i++) begin
      sel_a = 3'(i); sel_b = 3'(7 - i); ld_a = 1'b1; ld_b = 1'b1;
      tick();
      n_cmp++; if (op_a !== exp_tbl[i]) begin n_mis++; $display("FAIL decode_a[%0d]: got %h want %h", i, op_a, exp_tbl[i]); end
      n_cmp++; if (op_b !== exp_tbl[7-i]) begin n_mis++; $display("FAIL decode_b[%0d]: got %h want %h", 7-i, op_b, exp_tbl[7-i]); end
      n_cmp++; if (op_valid !== 1'b1) begin n_mis++; $display("FAIL decode_valid[%0d]: got %b want 1", i, op_valid); end
    end
    idle_strobes();
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL decode_drain: got %b want 0", op_valid); end
  endtask

  task automatic test_back_to_back;
    sel_a = 3'd1; sel_b = 3'd2; ld_a = 1'b1; ld_b = 1'b1;
    tick();
    ld_b = 1'b0; alu_ack = 1'b1; sel_a = 3'd5; sp = 8'hFD;
    tick();
    idle_strobes();
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_valid: got %b want 0", op_valid); end
    n_cmp++; if (op_a !== 8'hFD) begin n_mis++; $display("FAIL b2b_op_a: got %h want fd", op_a); end
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL ack_ignored: got %b want 0", op_valid); end
    ld_b = 1'b1; sel_b = 3'd3; y_reg = 8'h5A;
    tick();
    ld_b = 1'b0;
    n_cmp++; if (op_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_ready: got %b want 1", op_valid); end
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    ld_b = 1'b1; sel_b = 3'd1; a_reg = 8'h21;
    tick();
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL haveb_first: got %b want 0", op_valid); end
    a_reg = 8'h42;
    tick();
    ld_b = 1'b0;
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL haveb_stay: got %b want 0", op_valid); end
    n_cmp++; if (op_b !== 8'h42) begin n_mis++; $display("FAIL haveb_overwrite: got %h want 42", op_b); end
    ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    n_cmp++; if (op_valid !== 1'b1) begin n_mis++; $display("FAIL haveb_ready: got %b want 1", op_valid); end
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0; alu_ack = 1'b1; ld_b = 1'b1; tmp_ld = 1'b1; alu_result = 8'hEE;
    tick();
    rst_n = 1'b1; idle_strobes();
    n_cmp++; if (op_a !== 8'h00) begin n_mis++; $display("FAIL mid_op_a: got %h want 00", op_a); end
    n_cmp++; if (op_b !== 8'h00) begin n_mis++; $display("FAIL mid_op_b: got %h want 00", op_b); end
    n_cmp++; if (tmp !== 8'h00) begin n_mis++; $display("FAIL mid_tmp: got %h want 00", tmp); end
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL mid_valid: got %b want 0", op_valid); end
    ld_a = 1'b1; sel_a = 3'd6;
    tick();
    ld_a = 1'b0;
    n_cmp++; if (op_valid !== 1'b0) begin n_mis++; $display("FAIL mid_empty: got %b want 0", op_valid); end
  endtask

  task automatic test_wide;
    sel_a = 3'd6; ld_a = 1'b1;
    tick();
    n_cmp++; if (op_a16 !== 16'h0001) begin n_mis++; $display("FAIL wide_one: got %h want 0001", op_a16); end
    sel_a = 3'd0; din16 = 16'hABCD;
    tick();
    ld_a = 1'b0;
    n_cmp++; if (op_a16 !== 16'hABCD) begin n_mis++; $display("FAIL wide_code0: got %h want abcd", op_a16); end
  endtask

  initial begin
    rst_n = 1'b0; idle_strobes();
    sel_a = 3'd0; sel_b = 3'd0;
    a_reg = 8'h00; x_reg = 8'h00; y_reg = 8'h00; data_in = 8'h00; sp = 8'h00; alu_result = 8'h00;
    a16 = 16'h1111; x16 = 16'h2222; y16 = 16'h3333; din16 = 16'h4444; sp16 = 16'h5555; res16 = 16'h6666;
    test_reset();
    test_both_load();
    test_staggered();
    test_tmp_no_bypass();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_W, default 8, width of every data source, operand and the TEMP register.
REQ-002 Parameter SEL_W, default 3, width of each operand select code; fixed at 3 in this generation.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port sel_a, sel_b  input  SEL_W  source codes for operand A and operand B.
REQ-006 Port ld_a, ld_b  input  1  capture strobes for operand A and operand B.
REQ-007 Port a_reg, x_reg, y_reg, data_in, sp  input  DATA_W  CPU register, bus and stack sources.
REQ-008 Port alu_result  input  DATA_W  ALU output, fed back into the TEMP register.
REQ-009 Port tmp_ld  input  1  capture strobe for the TEMP register.
REQ-010 Port alu_ack  input  1  ALU has consumed the current operand pair.
REQ-011 Port op_a, op_b  output  DATA_W  registered operands.
REQ-012 Port tmp  output  DATA_W  current TEMP register value.
REQ-013 Port op_valid  output  1  both operands loaded and not yet consumed.

Function
REQ-014 Source codes SHALL decode per channel as follows: 1=a_reg, 2=x_reg, 3=y_reg, 4=data_in, 5=sp, 6=constant one (zero-extended to DATA_W), 7=TEMP register, 0=data_in.
REQ-015 Operand A and operand B SHALL use independent decoders, so both channels may select the same source in the same cycle.
REQ-016 On a rising edge with ld_a=1, op_a SHALL take the source selected by sel_a; with ld_a=0, op_a SHALL hold its value.
REQ-017 Operand B SHALL behave the same way using ld_b and sel_b.
REQ-018 On a rising edge with tmp_ld=1, tmp SHALL take alu_result; otherwise tmp SHALL hold.
REQ-019 If code 7 is selected in the same cycle as tmp_ld, the operand SHALL capture the old TEMP value; there is no bypass.
REQ-020 The handshake FSM SHALL have four states: EMPTY, HAVE_A, HAVE_B and READY.
REQ-021 op_valid SHALL be 1 only in READY and SHALL be driven directly from the state register.
REQ-022 Transitions from EMPTY: ld_a alone -> HAVE_A; ld_b alone -> HAVE_B; ld_a and ld_b together -> READY.
REQ-023 Transitions from HAVE_A: ld_b -> READY; ld_a alone -> stay in HAVE_A and overwrite op_a.
REQ-024 Transitions from HAVE_B: ld_a -> READY; ld_b alone -> stay in HAVE_B and overwrite op_b.
REQ-025 Transitions from READY: alu_ack with no load -> EMPTY; no ack and no load -> stay in READY.
REQ-026 In READY with alu_ack and a simultaneous load, the next state SHALL be computed as if from EMPTY with that load (back-to-back pipelining).
REQ-027 In READY without alu_ack, any load SHALL overwrite the operand and the state SHALL remain READY.
REQ-028 alu_ack in any state other than READY SHALL be ignored.
REQ-029 The latency from a load strobe to op_valid=1 SHALL be exactly 1 cycle.
REQ-030 The outputs SHALL contain no combinational path from any input.

Reset
REQ-031 While rst_n=0 at a clock edge: op_a=0, op_b=0, tmp=0, state=EMPTY and op_valid=0.
REQ-032 Reset SHALL override every simultaneous strobe, including ld_a, ld_b, tmp_ld and alu_ack.
REQ-033 Reset asserted mid-operation (HAVE_A, HAVE_B or READY) SHALL discard any partial operand pair.
REQ-034 Before the first reset edge, output values are undefined; verification SHALL check outputs only after reset.

Verification
REQ-035 Reset, then sel_a=1 with a_reg=0x3C, sel_b=6, and ld_a, ld_b pulsed together -> next cycle op_a=0x3C, op_b=0x01, op_valid=1.
REQ-036 Pulse ld_a (sel_a=2, x_reg=0x10), then ld_b two cycles later (sel_b=4, data_in=0xF0) -> op_valid=0 until the cycle after ld_b, then 1 with op_a=0x10, op_b=0xF0.
REQ-037 tmp_ld with alu_result=0x7F, next cycle tmp_ld with alu_result=0x80 and ld_a with sel_a=7 in that same cycle -> op_a=0x7F, tmp=0x80.
REQ-038 In READY, alu_ack together with ld_a (sel_a=5, sp=0xFD) -> next state HAVE_A, op_valid=0, op_a=0xFD.
REQ-039 In READY, rst_n=0 together with alu_ack and ld_b -> op_a=op_b=tmp=0, op_valid=0, state EMPTY.
REQ-040 With DATA_W=16 and sel_a=6 -> op_a=0x0001; with sel_a=0 -> op_a=data_in.
